// File: rtl/player_shot_ctrl.sv
// Player cannon and bullet game state, updated once per video frame.
// Produces registered cannon/bullet coordinates for the pixel painter.
//
// Ports:
//   clk_i            pixel clock
//   reset_n_i        asynchronous active-low reset
//   frame_i          one-cycle strobe at the start of vertical blanking
//   left_i/right_i   synchronized direction button levels
//   shoot_i          synchronized shoot button level
//   hit_i            one-cycle collision pulse for the live bullet
//   player_x_o       cannon left edge
//   bullet_x_o       bullet column (one pixel wide)
//   bullet_y_o       bullet top row
//   bullet_active_o  bullet is in flight and should be drawn
//   shot_fired_o     one-cycle pulse in the first cycle of a flight
module player_shot_ctrl #(
    parameter int CORDW           = 10,
    parameter int SCREEN_W        = 640,
    parameter int PLAYER_W        = 14,
    parameter int PLAYER_Y        = 401,
    parameter int PLAYER_SPEED    = 2,
    parameter int BULLET_H        = 6,
    parameter int BULLET_SPEED    = 4,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             frame_i,
    input  logic             left_i,
    input  logic             right_i,
    input  logic             shoot_i,
    input  logic             hit_i,
    output logic [CORDW-1:0] player_x_o,
    output logic [CORDW-1:0] bullet_x_o,
    output logic [CORDW-1:0] bullet_y_o,
    output logic             bullet_active_o,
    output logic             shot_fired_o
);

    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        COOLDOWN
    } state_t;

    localparam logic [CORDW-1:0] X_MAX  = CORDW'(SCREEN_W - PLAYER_W);
    localparam logic [CORDW-1:0] X_RST  = CORDW'((SCREEN_W - PLAYER_W) / 2);
    localparam logic [CORDW-1:0] X_STEP = CORDW'(PLAYER_SPEED);
    localparam logic [CORDW-1:0] B_OFF  = CORDW'(PLAYER_W / 2);
    localparam logic [CORDW-1:0] B_Y0   = CORDW'(PLAYER_Y - BULLET_H);
    localparam logic [CORDW-1:0] B_STEP = CORDW'(BULLET_SPEED);

    localparam int CNT_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // With no cooldown a finished flight returns straight to IDLE.
    localparam state_t END_STATE = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;

    state_t             state;
    logic [CNT_W-1:0]   cool_cnt;
    logic               shoot_pending;
    logic               shoot_prev;

    logic               shoot_edge;
    logic               shot_req;
    logic [CORDW-1:0]   x_next;

    // A press landing in the frame_i cycle itself still counts.
    always_comb begin
        shoot_edge = shoot_i & ~shoot_prev;
        shot_req   = shoot_pending | shoot_edge;
    end

    // Clamps compare before stepping so the unsigned value never wraps.
    always_comb begin
        x_next = player_x_o;
        if (left_i && !right_i) begin
            if (player_x_o >= X_STEP)
                x_next = player_x_o - X_STEP;
            else
                x_next = '0;
        end else if (right_i && !left_i) begin
            if (player_x_o <= X_MAX - X_STEP)
                x_next = player_x_o + X_STEP;
            else
                x_next = X_MAX;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state           <= IDLE;
            cool_cnt        <= '0;
            shoot_pending   <= 1'b0;
            shoot_prev      <= 1'b0;
            player_x_o      <= X_RST;
            bullet_x_o      <= '0;
            bullet_y_o      <= '0;
            bullet_active_o <= 1'b0;
            shot_fired_o    <= 1'b0;
        end else begin
            shoot_prev   <= shoot_i;
            shot_fired_o <= 1'b0;

            // Requests live for one frame only; no queuing across frames.
            if (frame_i)
                shoot_pending <= 1'b0;
            else if (shoot_edge)
                shoot_pending <= 1'b1;

            if (frame_i)
                player_x_o <= x_next;

            unique case (state)
                IDLE: begin
                    if (frame_i && shot_req) begin
                        state           <= FLYING;
                        bullet_active_o <= 1'b1;
                        shot_fired_o    <= 1'b1;
                        // Launch from the cannon position before this frame's move.
                        bullet_x_o      <= player_x_o + B_OFF;
                        bullet_y_o      <= B_Y0;
                    end
                end
                FLYING: begin
                    // A hit ends the flight immediately, ahead of any frame step.
                    if (hit_i) begin
                        state           <= END_STATE;
                        bullet_active_o <= 1'b0;
                        cool_cnt        <= CNT_LOAD;
                    end else if (frame_i) begin
                        if (bullet_y_o < B_STEP) begin
                            state           <= END_STATE;
                            bullet_active_o <= 1'b0;
                            cool_cnt        <= CNT_LOAD;
                        end else begin
                            bullet_y_o <= bullet_y_o - B_STEP;
                        end
                    end
                end
                COOLDOWN: begin
                    if (frame_i) begin
                        if (cool_cnt <= CNT_ONE) begin
                            state    <= IDLE;
                            cool_cnt <= '0;
                        end else begin
                            cool_cnt <= cool_cnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    bullet_active_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Self-checking bench for player_shot_ctrl against a frame-level
// behavioural model of cannon motion, shot capture and bullet lifetime.
module tb_player_shot_ctrl;

    localparam int X_MAX = 626;
    localparam int X_RST = 313;
    localparam int COOL  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       shoot = 1'b0;
    logic       hit = 1'b0;
    logic [9:0] player_x;
    logic [9:0] bullet_x;
    logic [9:0] bullet_y;
    logic       active;
    logic       fired;

    int total = 0;
    int bad = 0;

    // Reference model state
    int m_x, m_bx, m_by, m_lock;
    bit m_act, m_fired, m_pend, m_prev;

    player_shot_ctrl dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .frame_i        (frame),
        .left_i         (left),
        .right_i        (right),
        .shoot_i        (shoot),
        .hit_i          (hit),
        .player_x_o     (player_x),
        .bullet_x_o     (bullet_x),
        .bullet_y_o     (bullet_y),
        .bullet_active_o(active),
        .shot_fired_o   (fired)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] got_vec();
        return {player_x, bullet_x, bullet_y, active, fired};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {10'(m_x), 10'(m_bx), 10'(m_by), m_act, m_fired};
    endfunction

    task automatic model_reset();
        m_x = X_RST; m_bx = 0; m_by = 0; m_lock = 0;
        m_act = 0; m_fired = 0; m_pend = 0; m_prev = 0;
    endtask

    // One clock of the game rules, using the inputs sampled at that edge.
    task automatic model_clk(bit f, bit l, bit r, bit s, bit h);
        bit edge_now;
        bit want;
        int old_x;
        edge_now = s && !m_prev;
        want = m_pend || edge_now;
        old_x = m_x;
        m_fired = 0;
        if (f && l && !r) m_x = (m_x < 2) ? 0 : m_x - 2;
        if (f && r && !l) m_x = (m_x + 2 > X_MAX) ? X_MAX : m_x + 2;
        if (m_act) begin
            if (h || (f && m_by < 4)) begin
                m_act = 0;
                m_lock = COOL;
            end else if (f) begin
                m_by = m_by - 4;
            end
        end else if (m_lock > 0) begin
            if (f) m_lock = m_lock - 1;
        end else if (f && want) begin
            m_act = 1;
            m_fired = 1;
            m_bx = old_x + 7;
            m_by = 395;
        end
        m_pend = f ? 0 : want;
        m_prev = s;
    endtask

    task automatic cyc(bit f, bit l, bit r, bit s, bit h);
        @(negedge clk);
        frame = f; left = l; right = r; shoot = s; hit = h;
        @(posedge clk);
        model_clk(f, l, r, s, h);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        frame = 0; left = 0; right = 0; shoot = 0; hit = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic gap(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset_dut();
        total++;
        if (got_vec() !== {10'd313, 10'd0, 10'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: got %h want %h", got_vec(),
                     {10'd313, 10'd0, 10'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_motion();
        reset_dut();
        for (int i = 0; i < 200; i++) begin
            cyc(1, 0, 1, 0, 0);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL motion_right[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        total++;
        if (player_x !== 10'd626) begin
            bad++;
            $display("FAIL right_saturate: got %0d want 626", player_x);
        end
        for (int i = 0; i < 400; i++) begin
            cyc(1, 1, 0, 0, 0);
            if (got_vec() !== exp_vec()) begin
                total++;
                bad++;
                $display("FAIL motion_left[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        total++;
        if (player_x !== 10'd0) begin
            bad++;
            $display("FAIL left_saturate: got %0d want 0", player_x);
        end
        // Both buttons: no motion
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        total++;
        if (player_x !== 10'd2) begin
            bad++;
            $display("FAIL both_buttons: got %0d want 2", player_x);
        end
    endtask

    task automatic test_fire_flight();
        reset_dut();
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        total++;
        if (got_vec() !== {10'd313, 10'd320, 10'd395, 1'b1, 1'b1}
            || exp_vec() !== got_vec()) begin
            bad++;
            $display("FAIL launch: got %h want %h", got_vec(), exp_vec());
        end
        cyc(0, 0, 0, 0, 0);
        total++;
        if (fired !== 1'b0) begin
            bad++;
            $display("FAIL fired_width: got %b want 0", fired);
        end
        for (int i = 0; i < 98; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (got_vec() !== exp_vec()) begin
                total++;
                bad++;
                $display("FAIL flight[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        total++;
        if (bullet_y !== 10'd3 || active !== 1'b1) begin
            bad++;
            $display("FAIL flight_top: got y=%0d act=%b want y=3 act=1", bullet_y, active);
        end
        cyc(1, 0, 0, 0, 0);
        total++;
        if (active !== 1'b0 || bullet_y !== 10'd3) begin
            bad++;
            $display("FAIL offscreen: got act=%b y=%0d want act=0 y=3", active, bullet_y);
        end
        for (int k = 0; k < COOL; k++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(1, 0, 0, 0, 0);
            total++;
            if (fired !== 1'b0 || active !== 1'b0 || got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL cooldown_lock[%0d]: got %h want %h", k, got_vec(), exp_vec());
            end
        end
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        total++;
        if (fired !== 1'b1 || active !== 1'b1) begin
            bad++;
            $display("FAIL refire: got fired=%b act=%b want 1 1", fired, active);
        end
    endtask

    task automatic test_hit();
        reset_dut();
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            gap($urandom_range(0, 3));
            cyc(1, 0, 0, 0, 0);
        end
        gap($urandom_range(1, 5));
        cyc(0, 0, 0, 0, 1);
        total++;
        if (active !== 1'b0 || got_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL hit_midframe: got %h want %h", got_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            gap($urandom_range(0, 2));
            cyc(1, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        total++;
        if (fired !== 1'b0 || active !== 1'b0) begin
            bad++;
            $display("FAIL hit_lockout: got fired=%b act=%b want 0 0", fired, active);
        end
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        total++;
        if (fired !== 1'b1 || got_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL hit_refire: got %h want %h", got_vec(), exp_vec());
        end
        // Hit while not flying has no effect
        reset_dut();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        total++;
        if (fired !== 1'b1) begin
            bad++;
            $display("FAIL hit_idle_ignored: got fired=%b want 1", fired);
        end
    endtask

    task automatic test_hold();
        int shots;
        reset_dut();
        shots = 0;
        for (int i = 0; i < 50; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                cyc(0, 0, 0, 1, 0);
                shots += int'(fired);
            end
            cyc(1, 0, 0, 1, 0);
            shots += int'(fired);
            if (got_vec() !== exp_vec()) begin
                total++;
                bad++;
                $display("FAIL hold[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        total++;
        if (shots != 1) begin
            bad++;
            $display("FAIL hold_one_shot: got %0d shots want 1", shots);
        end
        reset_dut();
        cyc(1, 0, 0, 1, 0);
        total++;
        if (fired !== 1'b1 || bullet_y !== 10'd395) begin
            bad++;
            $display("FAIL edge_on_frame: got fired=%b y=%0d want 1 395", fired, bullet_y);
        end
    endtask

    task automatic test_coincident();
        logic [9:0] y_before;
        reset_dut();
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
        y_before = bullet_y;
        cyc(1, 0, 0, 0, 1);
        total++;
        if (active !== 1'b0 || bullet_y !== y_before || got_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL hit_with_frame: got act=%b y=%0d want act=0 y=%0d",
                     active, bullet_y, y_before);
        end
        // Seven frames still locked, eighth releases
        for (int i = 0; i < COOL - 1; i++) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        total++;
        if (fired !== 1'b0) begin
            bad++;
            $display("FAIL lock_eighth: got fired=%b want 0", fired);
        end
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        total++;
        if (fired !== 1'b1) begin
            bad++;
            $display("FAIL after_lock: got fired=%b want 1", fired);
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        cyc(1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        frame = 0; left = 0; right = 0; shoot = 0; hit = 0;
        model_reset();
        #1;
        total++;
        if (got_vec() !== {10'd313, 10'd0, 10'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got %h want %h", got_vec(),
                     {10'd313, 10'd0, 10'd0, 1'b0, 1'b0});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // A pending press is discarded by reset
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        shoot = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0);
        total++;
        if (fired !== 1'b0 || active !== 1'b0) begin
            bad++;
            $display("FAIL pending_lost: got fired=%b act=%b want 0 0", fired, active);
        end
    endtask

    task automatic test_random();
        bit s;
        reset_dut();
        s = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) s = ~s;
            cyc($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), s,
                $urandom_range(0, 39) == 0);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_motion();
        test_fire_flight();
        test_hit();
        test_hold();
        test_coincident();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
